nibble_serializer: RTL and testbench

- Accepts a 4-bit nibble over a valid/ready handshake and sends it as a serial frame on one output: start bit, then 4 data bits LSB first, then an optional parity bit, then a stop bit.
- Generates the 2-bit bit-select that walks the 4:1 data-bit selection. That select is also exported so a downstream 4:1 mux stage can run in lock-step.
- Sits between the switch/register input logic and the serial output/LED pin of the lab board.

---
 rtl/nibble_ser_pkg.sv | 15 +
 rtl/bit_tick_gen.sv | 30 +++
 rtl/nibble_serializer.sv | 133 +++++++++++++
 tb/tb_nibble_serializer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_ser_pkg.sv
// Shared types and line levels for the nibble serializer.
package nibble_ser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period down-counter: ticks on the last cycle of every serial bit.
module bit_tick_gen #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);

    if (BIT_CYCLES == 0 || BIT_CYCLES > 65535) begin : g_bad_bit_cycles
        $error("bit_tick_gen: BIT_CYCLES must be in 1..65535");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/nibble_serializer.sv
// Serializes a handshaked nibble as start / 4 data bits LSB first / optional parity / stop.
module nibble_serializer
    import nibble_ser_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 4,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] sel2,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic [3:0] nib;
    logic [3:0] nib_nxt;
    logic [1:0] sel_nxt;
    logic [1:0] sel_inc;
    logic       tx_nxt;
    logic       ready_nxt;
    logic       busy_nxt;
    logic       clear;
    logic       tick;
    logic       parity_bit;

    bit_tick_gen #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    assign parity_bit = (^nib) ^ PARITY_ODD;
    assign sel_inc    = sel2 + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            nib       <= '0;
            sel2      <= '0;
            tx_out    <= TX_IDLE_LVL;
            din_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            nib       <= nib_nxt;
            sel2      <= sel_nxt;
            tx_out    <= tx_nxt;
            din_ready <= ready_nxt;
            busy      <= busy_nxt;
        end
    end

    // Line value and state are registered one step ahead, so tx_out changes on the bit edge.
    always_comb begin
        state_nxt = state;
        nib_nxt   = nib;
        sel_nxt   = sel2;
        tx_nxt    = tx_out;
        ready_nxt = din_ready;
        busy_nxt  = busy;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    nib_nxt   = din;
                    clear     = 1'b1;
                    state_nxt = START;
                    tx_nxt    = TX_START_LVL;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    sel_nxt   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    sel_nxt   = '0;
                    tx_nxt    = nib[0];
                end
            end
            DATA: begin
                if (tick) begin
                    sel_nxt = sel_inc;
                    if (sel2 == 2'd3) begin
                        if (PARITY_EN) begin
                            state_nxt = PARITY;
                            tx_nxt    = parity_bit;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = TX_IDLE_LVL;
                        end
                    end else begin
                        tx_nxt = nib[sel_inc];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    tx_nxt    = TX_IDLE_LVL;
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = TX_IDLE_LVL;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                sel_nxt   = '0;
            end
        endcase
    end

    // Decoded purely from flops (state and counter), so it carries no input-to-output path.
    assign done = (state == STOP) && tick;

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed self-checking bench for nibble_serializer (two parameter sets).
module tb_nibble_serializer;

    logic       clk;
    logic       rst_a, rst_b;
    logic [3:0] din_a, din_b;
    logic       din_valid_a, din_valid_b;
    logic       din_ready_a, din_ready_b;
    logic [1:0] sel2_a, sel2_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nibble_serializer #(
        .BIT_CYCLES(4),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .din      (din_a),
        .din_valid(din_valid_a),
        .din_ready(din_ready_a),
        .sel2     (sel2_a),
        .tx_out   (tx_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    nibble_serializer #(
        .BIT_CYCLES(1),
        .PARITY_EN (1'b0),
        .PARITY_ODD(1'b1)
    ) dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .din      (din_b),
        .din_valid(din_valid_b),
        .din_ready(din_ready_b),
        .sel2     (sel2_b),
        .tx_out   (tx_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        din_valid_a = 1'b1; din_a = 4'h7;
        din_valid_b = 1'b0; din_b = 4'h0;
        repeat (2) @(negedge clk);
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx_a: got %b expected 1", tx_a); end
        checks++; if (din_ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b expected 1", din_ready_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
        checks++; if (sel2_a !== 2'd0) begin errors++; $display("FAIL reset_sel2_a: got %0d expected 0", sel2_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
        checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx_b: got %b expected 1", tx_b); end
        checks++; if (din_ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b expected 1", din_ready_b); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
        rst_a = 1'b0; rst_b = 1'b0; din_valid_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // din = 1011: slots start,d0..d3,parity,stop = 0,1,1,0,1,1,1
    task automatic test_even_parity();
        logic [6:0] slots;
        logic       exp_tx;
        logic [1:0] exp_sel;
        slots = 7'b1110110;
        din_a = 4'b1011; din_valid_a = 1'b1;
        checks++; if (din_ready_a !== 1'b1) begin errors++; $display("FAIL even_ready_c0: got %b expected 1", din_ready_a); end
        @(negedge clk);
        din_valid_a = 1'b0;
        for (int c = 1; c <= 29; c++) begin
            if (c > 1) @(negedge clk);
            exp_tx  = (c <= 28) ? slots[(c - 1) / 4] : 1'b1;
            exp_sel = (c >= 5 && c <= 20) ? 2'((c - 5) / 4) : 2'd0;
            checks++; if (tx_a !== exp_tx) begin errors++; $display("FAIL even_tx c=%0d: got %b expected %b", c, tx_a, exp_tx); end
            checks++; if (sel2_a !== exp_sel) begin errors++; $display("FAIL even_sel2 c=%0d: got %0d expected %0d", c, sel2_a, exp_sel); end
            checks++; if (done_a !== (c == 28)) begin errors++; $display("FAIL even_done c=%0d: got %b expected %b", c, done_a, (c == 28)); end
            checks++; if (busy_a !== (c <= 28)) begin errors++; $display("FAIL even_busy c=%0d: got %b expected %b", c, busy_a, (c <= 28)); end
            checks++; if (din_ready_a !== (c >= 29)) begin errors++; $display("FAIL even_ready c=%0d: got %b expected %b", c, din_ready_a, (c >= 29)); end
        end
    endtask

    // BIT_CYCLES=1, no parity bit: 0,0,0,0,0,1 then idle
    task automatic test_no_parity();
        logic [6:0] exp_line;
        logic [1:0] exp_sel;
        exp_line = 7'b1100000;
        din_b = 4'h0; din_valid_b = 1'b1;
        @(negedge clk);
        din_valid_b = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            exp_sel = (c >= 2 && c <= 5) ? 2'(c - 2) : 2'd0;
            checks++; if (tx_b !== exp_line[c - 1]) begin errors++; $display("FAIL nopar_tx c=%0d: got %b expected %b", c, tx_b, exp_line[c - 1]); end
            checks++; if (sel2_b !== exp_sel) begin errors++; $display("FAIL nopar_sel2 c=%0d: got %0d expected %0d", c, sel2_b, exp_sel); end
            checks++; if (done_b !== (c == 6)) begin errors++; $display("FAIL nopar_done c=%0d: got %b expected %b", c, done_b, (c == 6)); end
            checks++; if (din_ready_b !== (c == 7)) begin errors++; $display("FAIL nopar_ready c=%0d: got %b expected %b", c, din_ready_b, (c == 7)); end
        end
    endtask

    // A = 1010 -> data 0,1,0,1 ; 5 = 0101 -> data 1,0,1,0
    task automatic test_back_to_back();
        logic [3:0] n1, n2;
        int         idx;
        n1 = 4'hA; n2 = 4'h5;
        din_a = n1; din_valid_a = 1'b1;
        @(negedge clk);
        din_a = n2;
        for (int c = 1; c <= 58; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 28) begin
                checks++; if (din_ready_a !== 1'b0) begin errors++; $display("FAIL b2b_ready_low c=%0d: got %b expected 0", c, din_ready_a); end
            end
            if (c == 5 || c == 9 || c == 13 || c == 17) begin
                idx = (c - 5) / 4;
                checks++; if (tx_a !== n1[idx]) begin errors++; $display("FAIL b2b_f1_bit%0d: got %b expected %b", idx, tx_a, n1[idx]); end
            end
            if (c == 28) begin
                checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_f1_done: got %b expected 1", done_a); end
            end
            if (c == 29) begin
                checks++; if (din_ready_a !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready: got %b expected 1", din_ready_a); end
                checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b expected 0", busy_a); end
            end
            if (c == 30) begin
                checks++; if (din_ready_a !== 1'b0) begin errors++; $display("FAIL b2b_f2_accept_ready: got %b expected 0", din_ready_a); end
                checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL b2b_f2_start: got %b expected 0", tx_a); end
                din_valid_a = 1'b0;
            end
            if (c == 34 || c == 38 || c == 42 || c == 46) begin
                idx = (c - 34) / 4;
                checks++; if (tx_a !== n2[idx]) begin errors++; $display("FAIL b2b_f2_bit%0d: got %b expected %b", idx, tx_a, n2[idx]); end
            end
            if (c == 57) begin
                checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_f2_done: got %b expected 1", done_a); end
            end
            if (c == 58) begin
                checks++; if (din_ready_a !== 1'b1) begin errors++; $display("FAIL b2b_f2_end_ready: got %b expected 1", din_ready_a); end
            end
        end
    endtask

    // latched 0011: data 1,1,0,0, even parity 0; din forced to F mid-data
    task automatic test_din_change();
        logic [3:0] sent;
        int         idx;
        sent = 4'b0011;
        din_a = sent; din_valid_a = 1'b1;
        @(negedge clk);
        din_valid_a = 1'b0;
        for (int c = 1; c <= 29; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 5 || c == 9 || c == 13 || c == 17) begin
                idx = (c - 5) / 4;
                checks++; if (tx_a !== sent[idx]) begin errors++; $display("FAIL dinchg_bit%0d: got %b expected %b", idx, tx_a, sent[idx]); end
            end
            if (c == 6) din_a = 4'hF;
            if (c == 21) begin
                checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL dinchg_parity: got %b expected 0", tx_a); end
            end
            if (c == 28) begin
                checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL dinchg_done: got %b expected 1", done_a); end
            end
        end
    endtask

    // din = 0110; reset while sel2 = 2
    task automatic test_rst_mid();
        din_a = 4'b0110; din_valid_a = 1'b1;
        @(negedge clk);
        din_valid_a = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (sel2_a !== 2'd2) begin errors++; $display("FAIL rstmid_sel2_pre: got %0d expected 2", sel2_a); end
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rstmid_bit2: got %b expected 1", tx_a); end
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx_a); end
        checks++; if (sel2_a !== 2'd0) begin errors++; $display("FAIL rstmid_sel2: got %0d expected 0", sel2_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
        checks++; if (din_ready_a !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", din_ready_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done_a); end
        for (int c = 16; c <= 34; c++) begin
            @(negedge clk);
            checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rstmid_no_done c=%0d: got %b expected 0", c, done_a); end
            checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rstmid_idle_tx c=%0d: got %b expected 1", c, tx_a); end
        end
    endtask

    // din = 1001: data 1,0,0,1, even parity 0
    task automatic test_rst_at_accept();
        rst_a = 1'b1; din_a = 4'b1001; din_valid_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; din_valid_a = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstacc_busy: got %b expected 0", busy_a); end
        checks++; if (din_ready_a !== 1'b1) begin errors++; $display("FAIL rstacc_ready: got %b expected 1", din_ready_a); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rstacc_idle_tx i=%0d: got %b expected 1", i, tx_a); end
            @(negedge clk);
        end
        din_valid_a = 1'b1;
        @(negedge clk);
        din_valid_a = 1'b0;
        for (int c = 1; c <= 29; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) begin
                checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL rstacc_start: got %b expected 0", tx_a); end
                checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rstacc_busy1: got %b expected 1", busy_a); end
            end
            if (c == 5) begin
                checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rstacc_bit0: got %b expected 1", tx_a); end
            end
            if (c == 9) begin
                checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL rstacc_bit1: got %b expected 0", tx_a); end
            end
            if (c == 21) begin
                checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL rstacc_parity: got %b expected 0", tx_a); end
            end
            if (c == 28) begin
                checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rstacc_done: got %b expected 1", done_a); end
            end
            if (c == 29) begin
                checks++; if (din_ready_a !== 1'b1) begin errors++; $display("FAIL rstacc_ready_end: got %b expected 1", din_ready_a); end
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        din_a = '0; din_b = '0;
        din_valid_a = 1'b0; din_valid_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_even_parity();
        test_no_parity();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_din_change();
        @(negedge clk);
        test_rst_mid();
        test_rst_at_accept();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
